// File: rtl/shifter_operand_pipe.sv
// Two-stage shifter-operand / immediate-extension unit feeding ALU operand 2 and the shifter carry.
// S1 registers the request with a normalised amount and effective op; S2 computes and holds the result.
module shifter_operand_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_op,
  input  logic             i_imm_form,
  input  logic [7:0]       i_amount,
  input  logic [WIDTH-1:0] i_operand,
  input  logic             i_carry_in,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out,
  output logic             o_carry_out
);

  localparam int LW = $clog2(WIDTH);
  localparam logic [7:0] NMASK = 8'(WIDTH - 1);
  localparam logic [7:0] NFULL = 8'(WIDTH);

  typedef enum logic [2:0] {
    OP_LSL    = 3'b000,
    OP_LSR    = 3'b001,
    OP_ASR    = 3'b010,
    OP_ROR    = 3'b011,
    OP_RRX    = 3'b100,
    OP_IMMROT = 3'b101,
    OP_ZEXT12 = 3'b110,
    OP_SEXT24 = 3'b111
  } op_t;

  logic             r_s1Valid;
  op_t              r_s1Op;
  logic [7:0]       r_s1N;
  logic [WIDTH-1:0] r_s1Operand;
  logic             r_s1Carry;
  logic             r_s2Valid;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;

  logic             w_s2Advance;
  logic             w_s1Load;
  op_t              w_effOp;
  logic [7:0]       w_n;
  logic [7:0]       w_immN;

  assign w_s2Advance = !r_s2Valid || i_out_ready;
  assign w_s1Load    = !r_s1Valid || w_s2Advance;
  assign o_in_ready  = !i_reset && w_s1Load;
  assign w_immN      = i_amount & NMASK;

  // Fold the zero-amount special cases into plain ops so S2 never sees them.
  always_comb begin
    w_effOp = op_t'(i_op);
    w_n     = i_amount;
    case (op_t'(i_op))
      OP_LSL, OP_LSR, OP_ASR, OP_ROR: begin
        if (i_imm_form) begin
          w_n = w_immN;
          if (w_immN == 8'd0) begin
            if (op_t'(i_op) == OP_LSR || op_t'(i_op) == OP_ASR) w_n = NFULL;
            else if (op_t'(i_op) == OP_ROR) w_effOp = OP_RRX;
          end
        end else if (i_amount == 8'd0) begin
          w_effOp = OP_LSL;
        end
      end
      OP_IMMROT: w_n = {3'b000, i_amount[3:0], 1'b0} & NMASK;
      default:   w_n = 8'd0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1Valid   <= 1'b0;
      r_s1Op      <= OP_LSL;
      r_s1N       <= 8'd0;
      r_s1Operand <= '0;
      r_s1Carry   <= 1'b0;
    end else if (i_flush) begin
      r_s1Valid <= 1'b0;
    end else if (w_s1Load) begin
      r_s1Valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1Op      <= w_effOp;
        r_s1N       <= w_n;
        r_s1Operand <= i_operand;
        r_s1Carry   <= i_carry_in;
      end
    end
  end

  logic [WIDTH:0]         w_lslWide;
  logic [WIDTH:0]         w_lsrWide;
  logic signed [WIDTH:0]  w_asrWide;
  logic [WIDTH-1:0]       w_rotSrc;
  logic [LW-1:0]          w_rotK;
  logic [2*WIDTH-1:0]     w_rotWide;
  logic [WIDTH-1:0]       w_sext;
  logic [WIDTH-1:0]       w_result;
  logic                   w_carry;

  // An extra bit beside the operand catches the last bit shifted out, so it doubles as the carry.
  assign w_lslWide = {1'b0, r_s1Operand} << r_s1N;
  assign w_lsrWide = {r_s1Operand, 1'b0} >> r_s1N;
  assign w_asrWide = $signed({r_s1Operand, 1'b0}) >>> r_s1N;
  assign w_rotSrc  = (r_s1Op == OP_IMMROT) ? {{(WIDTH-8){1'b0}}, r_s1Operand[7:0]} : r_s1Operand;
  assign w_rotK    = r_s1N[LW-1:0];
  assign w_rotWide = {w_rotSrc, w_rotSrc} >> w_rotK;

  if (WIDTH >= 24) begin : g_sextWide
    assign w_sext = {{(WIDTH-24){r_s1Operand[23]}}, r_s1Operand[23:0]} << 2;
  end else begin : g_sextNarrow
    assign w_sext = r_s1Operand << 2;
  end

  always_comb begin
    w_result = r_s1Operand;
    w_carry  = r_s1Carry;
    case (r_s1Op)
      OP_LSL: begin
        if (r_s1N != 8'd0) begin
          w_result = w_lslWide[WIDTH-1:0];
          w_carry  = w_lslWide[WIDTH];
        end
      end
      OP_LSR: begin
        w_result = w_lsrWide[WIDTH:1];
        w_carry  = w_lsrWide[0];
      end
      OP_ASR: begin
        w_result = w_asrWide[WIDTH:1];
        w_carry  = w_asrWide[0];
      end
      OP_ROR: begin
        w_result = w_rotWide[WIDTH-1:0];
        w_carry  = w_rotWide[WIDTH-1];
      end
      OP_RRX: begin
        w_result = {r_s1Carry, r_s1Operand[WIDTH-1:1]};
        w_carry  = r_s1Operand[0];
      end
      OP_IMMROT: begin
        w_result = w_rotWide[WIDTH-1:0];
        if (r_s1N != 8'd0) w_carry = w_rotWide[WIDTH-1];
      end
      OP_ZEXT12: w_result = {{(WIDTH-12){1'b0}}, r_s1Operand[11:0]};
      OP_SEXT24: w_result = w_sext;
      default: ;
    endcase
  end

  // Flush only drops valid; the data registers keep their stale contents.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s2Valid <= 1'b0;
      r_out     <= '0;
      r_carry   <= 1'b0;
    end else if (i_flush) begin
      r_s2Valid <= 1'b0;
    end else if (w_s2Advance) begin
      r_s2Valid <= r_s1Valid;
      if (r_s1Valid) begin
        r_out   <= w_result;
        r_carry <= w_carry;
      end
    end
  end

  assign o_out_valid = r_s2Valid;
  assign o_out       = r_out;
  assign o_carry_out = r_carry;

endmodule

// File: doc/shifter_operand_pipe.md
# shifter_operand_pipe

Parametrised, two-stage pipelined shifter-operand and immediate-extension unit for the data path. It generalises the datapath's combinational shift/sign-extend stage to a configurable word width. It adds register-specified shift amounts, RRX, fully defined carry-out for every amount, a valid/ready handshake and a pipeline flush. It sits between register-file read and the ALU, feeding the operand 2 value and the shifter carry.

## Interface
- WIDTH, 32, datapath width; power of two, 16..64
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high; clears all pipeline state
- flush  input  1  synchronous; discards both stages, lower priority than reset
- in_valid  input  1  request present
- in_ready  output  1  unit accepts a request this cycle
- op  input  3  000 LSL, 001 LSR, 010 ASR, 011 ROR, 100 RRX, 101 IMM_ROT, 110 ZEXT12, 111 SEXT24
- imm_form  input  1  1: amount[4:0] is an instruction immediate; 0: amount[7:0] is from a register
- amount  input  8  shift/rotate amount
- operand  input  WIDTH  Rm value, or instruction bits for IMM_ROT/ZEXT12/SEXT24
- carry_in  input  1  current C flag
- out_valid  output  1  result present
- out_ready  input  1  consumer takes result this cycle
- out  output  WIDTH  shifted/extended result
- carry_out  output  1  shifter carry

## Operation
- Stage 1 (S1) registers the request and normalises the amount to n, computing the effective op. Stage 2 (S2) performs the shift and computes the carry, then holds out/carry_out.
- Immediate form: n = amount[4:0] for W=32; generally n = amount[log2(W)-1:0].
  - LSR/ASR with n=0 means n=W.
  - ROR with n=0 means RRX.
  - LSL with n=0 passes operand and carry_in.
- Register form: n = amount[7:0].
  - n=0, any shift op: out=operand, carry_out=carry_in.
- LSL: 0<n<W gives operand<<n, carry=operand[W-n]. n=W gives 0, carry=operand[0]. n>W gives 0, carry=0.
- LSR: 0<n<W gives carry=operand[n-1]. n=W gives 0, carry=operand[W-1]. n>W gives 0, 0.
- ASR: 0<n<W gives arithmetic shift, carry=operand[n-1]. n>=W gives all bits = operand[W-1], and carry = operand[W-1].
- ROR: k = n mod W.
  - k=0 and n≠0: out=operand, carry=operand[W-1].
  - Otherwise: rotate right by k, carry=out[W-1].
- RRX: out={carry_in, operand[W-1:1]}, carry=operand[0]; amount is ignored.
- IMM_ROT: zero-extend operand[7:0], rotate right by 2*amount[3:0] mod W.
  - Rotate amount 0: carry=carry_in.
  - Otherwise: carry=out[W-1].
- ZEXT12: out={0, operand[11:0]}, carry=carry_in.
- SEXT24: out = sign-extend(operand[23:0]) << 2, truncated to W; carry=carry_in.
- All arithmetic is unsigned on n; no amount wraps except ROR/IMM_ROT modulo W.

## Timing
- Reset values: in_ready=0 during reset, 1 the cycle after; out_valid=0, out=0, carry_out=0, S1 valid=0.
- Accept: in_valid && in_ready at edge. Result is out_valid two edges later if unstalled; latency 2, throughput 1/cycle.
- Backpressure:
  - in_ready = !S1_valid || !S2_valid || out_ready. This is combinational from out_ready.
  - S2 advances when !S2_valid || out_ready.
- Hold: while out_valid && !out_ready, out and carry_out are stable and S1 holds its contents.
- Simultaneous transfers: accept and emit in the same cycle keep both stages full with no bubble.
- flush:
  - Clears S1/S2 valid at that edge. out_valid=0 the next cycle; out/carry_out keep their stale value.
  - A request offered in the flush cycle is dropped; in_ready stays asserted.
- Reset mid-operation: all in-flight requests are lost; outputs return to reset values the next cycle.

## Test plan
- Reset with W=32, then LSL imm n=4 on 0x8000_000F: out_valid rises 2 cycles after accept with out=0x0000_00F0, carry=0.
- Register form, all 32-bit boundaries on operand 0x8000_0001: LSL 32→0/1, LSL 33→0/0, LSR 32→0/1, ASR 40→0xFFFF_FFFF/1, ROR 64→0x8000_0001/1, n=0→operand/carry_in.
- Immediate edge cases: LSR imm 0 on 0x8000_0000 gives 0/1. ROR imm 0 with carry_in=1 on 0x2 (RRX) gives 0x8000_0001/0. IMM_ROT 0xFF rot 4 (by 8) gives 0xFF00_0000/1. SEXT24 0x80_0000 gives 0xFE00_0000.
- Backpressure: 4 back-to-back requests with out_ready low for 3 cycles. Verify in_ready drops after 2 accepted, outputs hold stable, and all 4 results appear in order with no loss or duplication.
- Flush with both stages full and a request offered: no out_valid the next cycle. A new request completes normally 2 cycles after acceptance.
- WIDTH=16 build: LSL reg 16 on 0x0001 gives 0/1. ROR 17 on 0x0003 gives 0x8001/1. ZEXT12 0xFABC gives 0x0ABC.
